// File: rtl/decode_queue_pkg.sv
// Shared instruction-decode definitions: op/funct constants, control-word bit
// indices and the queue entry layout used by decode_queue and decq_ctrl_lut.
package decode_queue_pkg;

  localparam int unsigned CTRL_W = 11;

  // Bit positions inside the 11-bit control word (MSB first as presented).
  localparam int unsigned CTRL_REGWRITE = 10;
  localparam int unsigned CTRL_REGDST   = 9;
  localparam int unsigned CTRL_ALUSRC   = 8;
  localparam int unsigned CTRL_BRANCH   = 7;
  localparam int unsigned CTRL_MEMWRITE = 6;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_JUMP     = 4;
  localparam int unsigned CTRL_IMM_ZEXT = 3;
  localparam int unsigned CTRL_LINK     = 2;
  localparam int unsigned CTRL_JR       = 1;
  localparam int unsigned CTRL_BNE      = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef struct packed {
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } decq_entry_t;

endpackage

// File: rtl/decq_ctrl_lut.sv
// Combinational main decoder: op/funct fields -> 11-bit control word plus an
// illegal-op flag. Only the op field and the JR funct are examined; other
// R-type functs pass through as a generic ALU op.
module decq_ctrl_lut
  import decode_queue_pkg::*;
(
  input  logic [5:0]        i_op,
  input  logic [5:0]        i_funct,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_illegal
);

  // Decode table; unknown ops yield an all-zero control word and flag illegal.
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl[CTRL_REGDST] = 1'b1;
        if (i_funct == FUNCT_JR) o_ctrl[CTRL_JR]       = 1'b1;
        else                     o_ctrl[CTRL_REGWRITE] = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_ctrl[CTRL_REGWRITE] = 1'b1;
        o_ctrl[CTRL_ALUSRC]   = 1'b1;
        o_ctrl[CTRL_IMM_ZEXT] = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        o_ctrl[CTRL_REGWRITE] = 1'b1;
        o_ctrl[CTRL_ALUSRC]   = 1'b1;
      end
      OP_LW: begin
        o_ctrl[CTRL_REGWRITE] = 1'b1;
        o_ctrl[CTRL_ALUSRC]   = 1'b1;
        o_ctrl[CTRL_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        o_ctrl[CTRL_ALUSRC]   = 1'b1;
        o_ctrl[CTRL_MEMWRITE] = 1'b1;
      end
      OP_BEQ: o_ctrl[CTRL_BRANCH] = 1'b1;
      OP_BNE: begin
        o_ctrl[CTRL_BRANCH] = 1'b1;
        o_ctrl[CTRL_BNE]    = 1'b1;
      end
      OP_J: o_ctrl[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        // Link target is r31; the regfile stage selects it from the link bit.
        o_ctrl[CTRL_JUMP]     = 1'b1;
        o_ctrl[CTRL_LINK]     = 1'b1;
        o_ctrl[CTRL_REGWRITE] = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Registered decode queue between fetch and decode/regfile. Decodes at push and
// buffers {instr, ctrl, illegal} in a DEPTH-entry FIFO with valid/ready, flush
// and a sticky illegal flag. Optional macro DECQ_STATS_EN adds per-class
// pop counters (br_count, mem_count, ill_count).
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_illegal,
  output logic              ill_sticky,
  output logic [CNT_W-1:0]  dec_count
`ifdef DECQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mem_count,
  output logic [CNT_W-1:0]  ill_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  decq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic              r_ill_sticky;
  logic [CNT_W-1:0]  r_dec_count;

  logic [CTRL_W-1:0] w_ctrl;
  logic              w_illegal;
  logic              w_push, w_pop;
  decq_entry_t       w_head;

  decq_ctrl_lut u_lut (
    .i_op      (instr[31:26]),
    .i_funct   (instr[5:0]),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  // Handshake: no bypass, so a full queue refuses input even while popping.
  always_comb begin
    in_ready  = (r_count != OCC_W'(DEPTH));
    out_valid = (r_count != '0);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
    w_head    = r_mem[r_rd_ptr];
  end

  // Head outputs are forced to zero whenever the queue is empty.
  always_comb begin
    out_instr   = out_valid ? w_head.instr   : '0;
    out_ctrl    = out_valid ? w_head.ctrl    : '0;
    out_illegal = out_valid ? w_head.illegal : 1'b0;
  end

  // Entry storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{instr: instr, ctrl: w_ctrl, illegal: w_illegal};
  end

  // Pointers, occupancy, sticky flag and pop counter; flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ill_sticky <= 1'b0;
      r_dec_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - OCC_W'(1);
      if (w_push && w_illegal) r_ill_sticky <= 1'b1;
      if (w_pop) r_dec_count <= r_dec_count + CNT_W'(1);
    end
  end

  assign ill_sticky = r_ill_sticky;
  assign dec_count  = r_dec_count;

`ifdef DECQ_STATS_EN
  logic [CNT_W-1:0] r_br_count, r_mem_count, r_ill_count;

  // Per-class counters bumped on pop from the head entry's decoded class.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count  <= '0;
      r_mem_count <= '0;
      r_ill_count <= '0;
    end else if (!flush && w_pop) begin
      if (w_head.ctrl[CTRL_BRANCH] | w_head.ctrl[CTRL_JUMP] | w_head.ctrl[CTRL_JR])
        r_br_count <= r_br_count + CNT_W'(1);
      if (w_head.ctrl[CTRL_MEMWRITE] | w_head.ctrl[CTRL_MEMTOREG])
        r_mem_count <= r_mem_count + CNT_W'(1);
      if (w_head.illegal) r_ill_count <= r_ill_count + CNT_W'(1);
    end
  end

  assign br_count  = r_br_count;
  assign mem_count = r_mem_count;
  assign ill_count = r_ill_count;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_decode_queue;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_ADDI = 32'h20010005;
  localparam logic [31:0] I_ORI  = 32'h34020007;
  localparam logic [31:0] I_SW   = 32'hAC030008;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_BEQ  = 32'h10220003;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, out_instr;
  logic [10:0] out_ctrl;
  logic        out_illegal, ill_sticky;
  logic [CNT_W-1:0] dec_count;
`ifdef DECQ_STATS_EN
  logic [CNT_W-1:0] br_count, mem_count, ill_count;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_ctrl    (out_ctrl),
    .out_illegal (out_illegal),
    .ill_sticky  (ill_sticky),
    .dec_count   (dec_count)
`ifdef DECQ_STATS_EN
    ,
    .br_count    (br_count),
    .mem_count   (mem_count),
    .ill_count   (ill_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the opcode table; returns {ctrl[10:0], illegal}.
  function automatic logic [11:0] mdl_dec(input logic [31:0] w);
    logic rw, rd, as, br, mw, mr, jp, iz, lk, jr, bn, ill;
    logic [5:0] op;
    op = w[31:26];
    {rw, rd, as, br, mw, mr, jp, iz, lk, jr, bn, ill} = '0;
    if (op == 6'd0) begin
      rd = 1;
      if (w[5:0] == 6'd8) jr = 1; else rw = 1;
    end
    else if (op[5:2] == 4'b0011) begin rw = 1; as = 1; iz = 1; end
    else if (op[5:2] == 4'b0010) begin rw = 1; as = 1; end
    else if (op == 6'd35) begin rw = 1; as = 1; mr = 1; end
    else if (op == 6'd43) begin as = 1; mw = 1; end
    else if (op == 6'd4)  br = 1;
    else if (op == 6'd5)  begin br = 1; bn = 1; end
    else if (op == 6'd2)  jp = 1;
    else if (op == 6'd3)  begin jp = 1; lk = 1; rw = 1; end
    else ill = 1;
    return {rw, rd, as, br, mw, mr, jp, iz, lk, jr, bn, ill};
  endfunction

  // Reference model state.
  logic [31:0]      mq[$];
  logic [CNT_W-1:0] m_dec, m_br, m_mem, m_ill;
  logic             m_sticky;
  logic [11:0]      m_d;
  bit               m_push, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dec = '0; m_br = '0; m_mem = '0; m_ill = '0; m_sticky = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_push = in_valid && (mq.size() != DEPTH);
      m_pop  = out_ready && (mq.size() != 0);
      if (m_pop) begin
        m_d = mdl_dec(mq[0]);
        m_dec++;
        if (m_d[8] | m_d[5] | m_d[2]) m_br++;
        if (m_d[7] | m_d[6]) m_mem++;
        if (m_d[0]) m_ill++;
        void'(mq.pop_front());
      end
      if (m_push) begin
        m_d = mdl_dec(instr);
        if (m_d[0]) m_sticky = 1'b1;
        mq.push_back(instr);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [11:0] c_d;
  always @(negedge clk) begin
    if (chk_en) begin
      c_d = (mq.size() != 0) ? mdl_dec(mq[0]) : 12'h000;
      chk("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("cmp_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("cmp_out_instr", out_instr, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("cmp_out_ctrl", 32'(out_ctrl), 32'(c_d[11:1]));
      chk("cmp_out_illegal", 32'(out_illegal), 32'(c_d[0]));
      chk("cmp_ill_sticky", 32'(ill_sticky), 32'(m_sticky));
      chk("cmp_dec_count", 32'(dec_count), 32'(m_dec));
`ifdef DECQ_STATS_EN
      chk("cmp_br_count", 32'(br_count), 32'(m_br));
      chk("cmp_mem_count", 32'(mem_count), 32'(m_mem));
      chk("cmp_ill_count", 32'(ill_count), 32'(m_ill));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [31:0] mix [4];

  initial begin
    mix[0] = I_BEQ; mix[1] = I_LW; mix[2] = I_ILL; mix[3] = I_ADDI;
    rst = 1; in_valid = 0; instr = '0; flush = 0; out_ready = 0;
    cyc(2);
    chk_en = 1; rst = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_ctrl", 32'(out_ctrl), 0);
    chk("rst_dec_count", 32'(dec_count), 0);

    // Single LW through a ready consumer.
    in_valid = 1; instr = I_LW; out_ready = 1; cyc(1); in_valid = 0;
    chk("lw_valid", 32'(out_valid), 1);
    chk("lw_ctrl", 32'(out_ctrl), 32'h520);
    chk("lw_cnt0", 32'(dec_count), 0);
    cyc(1);
    chk("lw_cnt1", 32'(dec_count), 1);

    // Backpressure: third instruction waits, order kept.
    out_ready = 0; in_valid = 1; instr = I_ADDI; cyc(1);
    instr = I_ORI; cyc(1);
    chk("full_in_ready", 32'(in_ready), 0);
    instr = I_SW; cyc(1);
    chk("hold_head", out_instr, I_ADDI);
    out_ready = 1; cyc(1);
    chk("order_b", out_instr, I_ORI);
    cyc(1); in_valid = 0;
    chk("order_c", out_instr, I_SW);
    cyc(1);
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_cnt", 32'(dec_count), 4);

    // Illegal op: queued with zero ctrl, sticky survives the pop.
    out_ready = 0; in_valid = 1; instr = I_ILL; cyc(1); in_valid = 0;
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_ctrl", 32'(out_ctrl), 0);
    chk("ill_sticky", 32'(ill_sticky), 1);
    out_ready = 1; cyc(1);
    chk("ill_sticky_after_pop", 32'(ill_sticky), 1);

    // Flush of a full queue while fetch keeps presenting.
    out_ready = 0; in_valid = 1; instr = I_ADDI; cyc(1);
    instr = I_ORI; cyc(1);
    chk("pre_flush_full", 32'(in_ready), 0);
    flush = 1; instr = I_SW; out_ready = 1; cyc(1);
    flush = 0; in_valid = 0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_dec_count", 32'(dec_count), 5);
    cyc(1);
    chk("flush_not_queued", 32'(out_valid), 0);

    // JR / JAL / BNE streamed with consumer ready.
    out_ready = 1; in_valid = 1; instr = I_JR; cyc(1);
    chk("jr_ctrl", 32'(out_ctrl), 32'h202);
    instr = I_JAL; cyc(1);
    chk("jal_ctrl", 32'(out_ctrl), 32'h414);
    instr = I_BNE; cyc(1);
    chk("bne_ctrl", 32'(out_ctrl), 32'h081);
    in_valid = 0; cyc(1);

    // Reset with an entry queued drops it and clears the sticky flag.
    out_ready = 0; in_valid = 1; instr = I_ADDI; cyc(1);
    in_valid = 0; rst = 1; cyc(1); rst = 0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_dec_count", 32'(dec_count), 0);
    chk("midrst_sticky", 32'(ill_sticky), 0);

    // 2^CNT_W + 3 pops: counter wraps to 3.
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 19; i++) begin
      instr = mix[i % 4];
      cyc(1);
    end
    in_valid = 0; cyc(1);
    chk("wrap_dec_count", 32'(dec_count), 3);
`ifdef DECQ_STATS_EN
    chk("stat_br", 32'(br_count), 5);
    chk("stat_mem", 32'(mem_count), 5);
    chk("stat_ill", 32'(ill_count), 5);
`endif
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
